// File: rtl/simon_playback_ctrl_if.sv
// Playback controller bus: game handshake, pattern memory read port and clock-divider pacing.
// master = surrounding game logic, slave = simon_playback_ctrl.
interface simon_playback_ctrl_if #(
  parameter int IDX_W = 4
);
  logic             tick;
  logic             div_clear;
  logic             start;
  logic             abort;
  logic [IDX_W:0]   length;
  logic [IDX_W-1:0] rd_addr;
  logic [1:0]       rd_data;
  logic [3:0]       led;
  logic             busy;
  logic             done;

  modport master (
    output tick, start, abort, length, rd_data,
    input  div_clear, rd_addr, led, busy, done
  );

  modport slave (
    input  tick, start, abort, length, rd_data,
    output div_clear, rd_addr, led, busy, done
  );
endinterface

// File: rtl/simon_playback_ctrl.sv
// Plays the stored Simon pattern on four one-hot LEDs, one step per ON/GAP tick window.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | divider cleared, colour read at rd_addr = idx
// ON    | LED lit, counting ON_TICKS ticks
// GAP   | LED dark, counting GAP_TICKS ticks
// DONE  | playback finished, done pulse issued on exit
module simon_playback_ctrl #(
  parameter int MAX_LEN   = 16,
  parameter int IDX_W     = 4,
  parameter int ON_TICKS  = 2,
  parameter int GAP_TICKS = 1,
  parameter int TCNT_W    = 4
) (
  input logic                clk,
  input logic                reset,
  simon_playback_ctrl_if.slave bus
);

  if (ON_TICKS < 1 || ON_TICKS >= (1 << TCNT_W) || GAP_TICKS < 0 ||
      GAP_TICKS >= (1 << TCNT_W) || MAX_LEN > (1 << IDX_W)) begin : g_bad_params
    $error("simon_playback_ctrl: ON_TICKS/GAP_TICKS/MAX_LEN do not fit TCNT_W/IDX_W");
  end

  typedef enum logic [2:0] {IDLE, LOAD, ON, GAP, DONE} state_t;

  localparam logic [IDX_W:0] MAX_LEN_W = (IDX_W+1)'(MAX_LEN);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    len_q;
  logic [TCNT_W-1:0] cnt;
  logic [3:0]        led_q;
  logic              busy_q;
  logic              done_q;
  logic              clr_q;

  logic [IDX_W:0]    len_clamp;
  logic [TCNT_W-1:0] cnt_inc;
  logic              on_end;
  logic              gap_end;
  logic              step_done;
  logic              last_step;

  assign len_clamp = (bus.length > MAX_LEN_W) ? MAX_LEN_W : bus.length;
  // Saturating increment keeps an undersized counter from wrapping back into range.
  assign cnt_inc   = (&cnt) ? cnt : cnt + TCNT_W'(1);
  assign on_end    = bus.tick && (cnt_inc == TCNT_W'(ON_TICKS));
  assign gap_end   = bus.tick && (cnt_inc == TCNT_W'(GAP_TICKS));
  assign step_done = (state == ON && GAP_TICKS == 0 && on_end) || (state == GAP && gap_end);
  assign last_step = ({1'b0, idx} == len_q - (IDX_W+1)'(1));

  assign bus.led       = led_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_clear = clr_q;
  assign bus.rd_addr   = idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      len_q  <= '0;
      cnt    <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      clr_q  <= 1'b0;
    end else if (bus.abort && state != IDLE) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            if (bus.length == '0) begin
              state <= DONE;
            end else begin
              len_q  <= len_clamp;
              idx    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              clr_q  <= 1'b1;
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          led_q <= 4'b0001 << bus.rd_data;
          cnt   <= '0;
          state <= ON;
        end
        ON: begin
          if (on_end) begin
            led_q <= '0;
            cnt   <= '0;
            state <= GAP;
          end else if (bus.tick) begin
            cnt <= cnt_inc;
          end
        end
        GAP: begin
          if (bus.tick && !gap_end) cnt <= cnt_inc;
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          led_q  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Step end overrides the ON->GAP move when there is no gap phase.
      if (step_done) begin
        cnt <= '0;
        if (last_step) begin
          busy_q <= 1'b0;
          state  <= DONE;
        end else begin
          idx   <= idx + IDX_W'(1);
          clr_q <= 1'b1;
          state <= LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Scoreboard bench for simon_playback_ctrl: expected LED/address/done events queued at start, checked by a monitor.
module tb_simon_playback_ctrl;
  localparam int ON_T  = 2;
  localparam int GAP_T = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  simon_playback_ctrl_if #(.IDX_W(4)) bus ();
  simon_playback_ctrl_if #(.IDX_W(4)) bus0 ();

  simon_playback_ctrl #(.MAX_LEN(16), .IDX_W(4), .ON_TICKS(ON_T), .GAP_TICKS(GAP_T), .TCNT_W(4))
    u_dut (.clk(clk), .reset(reset), .bus(bus));
  simon_playback_ctrl #(.MAX_LEN(16), .IDX_W(4), .ON_TICKS(2), .GAP_TICKS(0), .TCNT_W(4))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  logic [1:0] pat  [16];
  logic [1:0] pat0 [16];
  assign bus.rd_data  = pat[bus.rd_addr];
  assign bus0.rd_data = pat0[bus0.rd_addr];

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // tick every 4 cycles, optionally forced high
  int   cyc = 0;
  logic force_tick = 1'b0;
  initial begin
    bus.tick  = 1'b0;
    bus0.tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc = cyc + 1;
      bus.tick  = force_tick || (cyc % 4 == 0);
      bus0.tick = bus.tick;
    end
  end

  // scoreboard
  logic [3:0] exp_led   [$];
  int         exp_tk    [$];
  logic [3:0] exp_addr  [$];
  int         exp_steps [$];
  int         exp_dtk   [$];

  logic       sb_en = 1'b1;
  logic [3:0] prev_led = 4'd0;
  int tk = 0, on_cnt = 0, off_cnt = 0, done_cnt = 0, ncyc = 0;

  logic [3:0] prev0 = 4'd0;
  logic [3:0] log0_led [$];
  int         log0_tk  [$];
  int         log0_cyc [$];
  int tk0 = 0, tk0_total = 0, last_tk0_cyc = 0, done0_cyc = 0, done0_tk = 0, done0_cnt = 0;

  always @(negedge clk) begin
    ncyc++;
    if (!sb_en) begin
      prev_led = bus.led;
    end else begin
      if (bus.led !== prev_led) begin
        check_val("led_pending", exp_led.size() > 0, 1);
        if (exp_led.size() > 0) begin
          check_val("led_value", bus.led, exp_led.pop_front());
          check_val("led_ticks", tk, exp_tk.pop_front());
        end
        if (bus.led != 4'd0) on_cnt++; else off_cnt++;
        tk = 0;
        prev_led = bus.led;
      end
      if (bus.div_clear) begin
        check_val("addr_pending", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) check_val("rd_addr", bus.rd_addr, exp_addr.pop_front());
        check_val("load_busy", bus.busy, 1);
      end
      if (bus.done) begin
        check_val("done_pending", exp_steps.size() > 0, 1);
        if (exp_steps.size() > 0) begin
          check_val("done_steps", on_cnt, exp_steps.pop_front());
          check_val("done_ticks", tk, exp_dtk.pop_front());
        end
        check_val("done_busy", bus.busy, 0);
        check_val("done_led", bus.led, 0);
      end
    end
    if (bus.done) done_cnt++;
    if (bus.tick && bus.busy && !bus.div_clear) tk++;

    if (bus0.led !== prev0) begin
      log0_led.push_back(bus0.led);
      log0_tk.push_back(tk0);
      log0_cyc.push_back(ncyc);
      tk0 = 0;
      prev0 = bus0.led;
    end
    if (bus0.done) begin
      done0_cnt++;
      done0_cyc = ncyc;
      done0_tk  = tk0_total;
    end
    if (bus0.tick && bus0.busy && !bus0.div_clear) begin
      tk0++;
      tk0_total++;
      last_tk0_cyc = ncyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_led.delete(); exp_tk.delete(); exp_addr.delete(); exp_steps.delete(); exp_dtk.delete();
  endtask

  // queue expectations for a playback and pulse start for one cycle
  task automatic play(input int len);
    int n;
    n = (len > 16) ? 16 : len;
    for (int i = 0; i < n; i++) begin
      exp_led.push_back(4'b0001 << pat[i]);
      exp_tk.push_back(i == 0 ? 0 : GAP_T);
      exp_led.push_back(4'd0);
      exp_tk.push_back(ON_T);
      exp_addr.push_back(4'(i));
    end
    exp_steps.push_back(n);
    exp_dtk.push_back(n > 0 ? GAP_T : 0);
    on_cnt = 0; off_cnt = 0; tk = 0;
    bus.length = 5'(len);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      step();
      i++;
    end
    check_val("done_seen", done_cnt - d0, 1);
  endtask

  task automatic check_drained(input string tag);
    check_val(tag, exp_led.size() + exp_addr.size() + exp_steps.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, i;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.length = '0;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.length = '0;
    for (int k = 0; k < 16; k++) begin
      pat[k] = 2'd0;
      pat0[k] = 2'd0;
    end

    repeat (3) step();
    check_val("rst_led", bus.led, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_clr", bus.div_clear, 0);
    check_val("rst_addr", bus.rd_addr, 0);
    reset = 1'b0;
    repeat (2) step();

    // pattern {2,0,3}
    pat[0] = 2'd2; pat[1] = 2'd0; pat[2] = 2'd3;
    play(3);
    check_val("t1_load_clr", bus.div_clear, 1);
    check_val("t1_load_led", bus.led, 0);
    step();
    check_val("t1_led_cycle2", bus.led, 4'b0100);
    wait_done(300);
    step();
    check_val("t1_idle_busy", bus.busy, 0);
    check_val("t1_idle_done", bus.done, 0);
    check_drained("t1_drained");

    // length 0
    d0 = done_cnt;
    play(0);
    check_val("t2_c1_done", bus.done, 0);
    check_val("t2_c1_busy", bus.busy, 0);
    step();
    check_val("t2_c2_done", bus.done, 1);
    check_val("t2_c2_busy", bus.busy, 0);
    check_val("t2_c2_clr", bus.div_clear, 0);
    check_val("t2_c2_led", bus.led, 0);
    repeat (3) step();
    check_val("t2_done_once", done_cnt - d0, 1);
    check_drained("t2_drained");

    // length above MAX_LEN clamps to 16
    for (int k = 0; k < 16; k++) pat[k] = 2'($urandom_range(0, 3));
    d0 = done_cnt;
    play(20);
    wait_done(1500);
    repeat (5) step();
    check_val("t3_done_once", done_cnt - d0, 1);
    check_drained("t3_drained");

    // abort during second ON step, then restart from idx 0
    pat[0] = 2'd3; pat[1] = 2'd1; pat[2] = 2'd2;
    play(3);
    i = 0;
    while (on_cnt < 2 && i < 200) begin
      step();
      i++;
    end
    check_val("t4_reach_on2", on_cnt >= 2, 1);
    sb_en = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_val("t4_abort_led", bus.led, 0);
    check_val("t4_abort_busy", bus.busy, 0);
    check_val("t4_abort_clr", bus.div_clear, 0);
    check_val("t4_abort_done", bus.done, 0);
    flush();
    d0 = done_cnt;
    repeat (20) step();
    check_val("t4_no_done", done_cnt - d0, 0);
    sb_en = 1'b1;
    play(2);
    wait_done(300);
    step();
    check_drained("t4_drained");

    // tick in LOAD ignored, start while busy ignored, reset mid-GAP
    pat[0] = 2'd1; pat[1] = 2'd2; pat[2] = 2'd3;
    play(3);
    force_tick = 1'b1;
    step();
    force_tick = 1'b0;
    bus.start  = 1'b1;
    bus.length = 5'd1;
    step();
    bus.start  = 1'b0;
    i = 0;
    while (off_cnt < 2 && i < 200) begin
      step();
      i++;
    end
    check_val("t5_reach_gap2", off_cnt >= 2, 1);
    check_val("t5_busy_gap", bus.busy, 1);
    sb_en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("t5_rst_led", bus.led, 0);
    check_val("t5_rst_busy", bus.busy, 0);
    check_val("t5_rst_done", bus.done, 0);
    check_val("t5_rst_clr", bus.div_clear, 0);
    check_val("t5_rst_addr", bus.rd_addr, 0);
    flush();
    step();
    sb_en = 1'b1;

    // GAP_TICKS = 0 instance, pattern {1,1}
    pat0[0] = 2'd1; pat0[1] = 2'd1;
    log0_led.delete(); log0_tk.delete(); log0_cyc.delete();
    tk0 = 0; tk0_total = 0; done0_cnt = 0;
    bus0.length = 5'd2;
    bus0.start  = 1'b1;
    step();
    bus0.start  = 1'b0;
    i = 0;
    while (done0_cnt == 0 && i < 200) begin
      step();
      i++;
    end
    check_val("t6_done_seen", done0_cnt, 1);
    check_val("t6_led_events", log0_led.size(), 4);
    if (log0_led.size() == 4) begin
      check_val("t6_led0", log0_led[0], 4'b0010);
      check_val("t6_led1", log0_led[1], 4'b0000);
      check_val("t6_led2", log0_led[2], 4'b0010);
      check_val("t6_led3", log0_led[3], 4'b0000);
      check_val("t6_on1_ticks", log0_tk[1], 2);
      check_val("t6_load_ticks", log0_tk[2], 0);
      check_val("t6_on2_ticks", log0_tk[3], 2);
      check_val("t6_dark_len", log0_cyc[2] - log0_cyc[1], 1);
    end
    check_val("t6_total_ticks", done0_tk, 4);
    check_val("t6_done_delay", done0_cyc - last_tk0_cyc, 2);
    repeat (3) step();
    check_val("t6_done_once", done0_cnt, 1);
    check_val("t6_idle_busy", bus0.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
